// File: rtl/snn_train_sequencer.sv
// rtl/snn_train_sequencer.sv - frame-driven train/inference sequencer for the IZH spiking array
// Optional winner readout enabled by defining SNN_SEQ_WTA_EN.
module snn_train_sequencer #(
  parameter int N_IN        = 144,
  parameter int N_OUT       = 6,
  parameter int PERIOD      = 150,
  parameter int N_FRAMES    = 912,
  parameter int TRAIN_SLOT  = 10,
  parameter int UNTRAIN_OFS = 5,
  parameter int CNT_W       = 16,
  parameter int WIN_W       = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             TICK,
  input  logic             START,
  input  logic             ABORT,
  input  logic             TRAIN_MODE,
  input  logic             FRM_VALID,
  output logic             FRM_READY,
  input  logic [N_IN-1:0]  FRM_PIXELS,
  input  logic [N_OUT-1:0] FRM_LABEL,
  input  logic [N_OUT-1:0] OUT_SPIKES,
  output logic [N_IN-1:0]  IN_SPIKES,
  output logic [N_OUT-1:0] TEACH_SPIKES,
  output logic             EN_STDP,
  output logic             EN_ADDR,
  output logic             BUSY,
  output logic             DONE,
  output logic [CNT_W-1:0] UNDERRUN_CNT,
  output logic [WIN_W-1:0] WINNER,
  output logic             WINNER_VALID
);

  localparam int TW = $clog2(PERIOD);
  localparam int FW = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1;

  localparam logic [TW-1:0] T_LAST  = TW'(PERIOD - 1);
  localparam logic [TW-1:0] T_ADDR  = TW'(PERIOD - 2);
  localparam logic [TW-1:0] T_TRAIN = TW'(TRAIN_SLOT);
  localparam logic [TW-1:0] T_UNTR  = TW'(PERIOD - 1 - UNTRAIN_OFS);
  localparam logic [FW-1:0] F_LAST  = FW'(N_FRAMES - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_FIN} state_t;

  state_t           state, state_nxt;
  logic [TW-1:0]    t_q;
  logic [FW-1:0]    f_q;
  logic [N_IN-1:0]  pix_q;
  logic [N_OUT-1:0] lab_q;
  logic             mode_q;
  logic             frame_end;
  logic             hs;

  // A frame is consumed whenever LOAD sees a valid frame; a frame ends on the TICK at the last step.
  assign hs        = (state == S_LOAD) && FRM_VALID;
  assign frame_end = (state == S_RUN) && TICK && (t_q == T_LAST);

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; ABORT overrides every other event, including START.
  always_comb begin
    state_nxt = state;
    if (ABORT) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (START) state_nxt = S_LOAD;
        S_LOAD: if (FRM_VALID) state_nxt = S_RUN;
        S_RUN:  if (frame_end) state_nxt = (f_q == F_LAST) ? S_FIN : S_LOAD;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // State-decoded outputs.
  always_comb begin
    FRM_READY = (state == S_LOAD);
    BUSY      = (state != S_IDLE);
    DONE      = (state == S_FIN);
    EN_STDP   = mode_q && ((state == S_LOAD) || (state == S_RUN));
  end

  // Session bookkeeping: step/frame counters, latched frame, mode and underrun counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      t_q          <= '0;
      f_q          <= '0;
      pix_q        <= '0;
      lab_q        <= '0;
      mode_q       <= 1'b0;
      UNDERRUN_CNT <= '0;
    end else begin
      if ((state == S_IDLE) && START && !ABORT) begin
        f_q          <= '0;
        mode_q       <= TRAIN_MODE;
        UNDERRUN_CNT <= '0;
      end
      if (hs) begin
        pix_q <= FRM_PIXELS;
        lab_q <= FRM_LABEL;
        t_q   <= '0;
      end
      if ((state == S_LOAD) && TICK && !FRM_VALID && !ABORT && (UNDERRUN_CNT != '1))
        UNDERRUN_CNT <= UNDERRUN_CNT + CNT_W'(1);
      if ((state == S_RUN) && TICK) begin
        if (t_q == T_LAST) begin
          t_q <= '0;
          if (f_q != F_LAST) f_q <= f_q + FW'(1);
        end else begin
          t_q <= t_q + TW'(1);
        end
      end
    end
  end

  // One-cycle spike/strobe pulses, registered from the TICK that qualifies them.
  always_ff @(posedge CLK) begin
    if (RST) begin
      IN_SPIKES    <= '0;
      TEACH_SPIKES <= '0;
      EN_ADDR      <= 1'b0;
    end else begin
      IN_SPIKES    <= '0;
      TEACH_SPIKES <= '0;
      EN_ADDR      <= 1'b0;
      if (!ABORT && (state == S_RUN) && TICK) begin
        IN_SPIKES <= (t_q == T_LAST) ? pix_q : '0;
        EN_ADDR   <= mode_q && (t_q == T_ADDR);
        if (mode_q)
          TEACH_SPIKES <= ((t_q == T_TRAIN) ? lab_q : '0) | ((t_q == T_UNTR) ? ~lab_q : '0);
      end
    end
  end

`ifdef SNN_SEQ_WTA_EN
  logic             seen_q;
  logic [WIN_W-1:0] win_q;
  logic [WIN_W-1:0] low_idx;
  logic             spike_now;

  // Lowest-index set bit of the current output spike vector.
  always_comb begin
    low_idx = '0;
    for (int k = N_OUT - 1; k >= 0; k--)
      if (OUT_SPIKES[k]) low_idx = WIN_W'(k);
  end

  assign spike_now = (state == S_RUN) && (OUT_SPIKES != '0) && !seen_q;

  // First-spike capture per frame and the winner pulse at frame end.
  always_ff @(posedge CLK) begin
    if (RST) begin
      seen_q       <= 1'b0;
      win_q        <= '0;
      WINNER       <= '0;
      WINNER_VALID <= 1'b0;
    end else begin
      WINNER       <= '0;
      WINNER_VALID <= 1'b0;
      if (hs) begin
        seen_q <= 1'b0;
      end else if (spike_now) begin
        seen_q <= 1'b1;
        win_q  <= low_idx;
      end
      if (frame_end && !ABORT && (seen_q || spike_now)) begin
        WINNER_VALID <= 1'b1;
        WINNER       <= seen_q ? win_q : low_idx;
      end
    end
  end
`else
  logic unused_out_spikes;
  assign unused_out_spikes = ^OUT_SPIKES;
  assign WINNER            = '0;
  assign WINNER_VALID      = 1'b0;
`endif

endmodule

// File: tb/tb_snn_train_sequencer.sv
// tb/tb_snn_train_sequencer.sv - directed self-checking bench for snn_train_sequencer
module tb_snn_train_sequencer;

  localparam int N_IN        = 8;
  localparam int N_OUT       = 6;
  localparam int PERIOD      = 8;
  localparam int N_FRAMES    = 2;
  localparam int TRAIN_SLOT  = 1;
  localparam int UNTRAIN_OFS = 2;
  localparam int CNT_W       = 2;
  localparam int WIN_W       = 3;

`ifdef SNN_SEQ_WTA_EN
  localparam bit WTA = 1'b1;
`else
  localparam bit WTA = 1'b0;
`endif

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             TICK = 1'b0;
  logic             START = 1'b0;
  logic             ABORT = 1'b0;
  logic             TRAIN_MODE = 1'b0;
  logic             FRM_VALID = 1'b0;
  logic             FRM_READY;
  logic [N_IN-1:0]  FRM_PIXELS = '0;
  logic [N_OUT-1:0] FRM_LABEL = '0;
  logic [N_OUT-1:0] OUT_SPIKES = '0;
  logic [N_IN-1:0]  IN_SPIKES;
  logic [N_OUT-1:0] TEACH_SPIKES;
  logic             EN_STDP;
  logic             EN_ADDR;
  logic             BUSY;
  logic             DONE;
  logic [CNT_W-1:0] UNDERRUN_CNT;
  logic [WIN_W-1:0] WINNER;
  logic             WINNER_VALID;

  int n_vec = 0;
  int n_bad = 0;

  snn_train_sequencer #(
    .N_IN(N_IN), .N_OUT(N_OUT), .PERIOD(PERIOD), .N_FRAMES(N_FRAMES),
    .TRAIN_SLOT(TRAIN_SLOT), .UNTRAIN_OFS(UNTRAIN_OFS), .CNT_W(CNT_W), .WIN_W(WIN_W)
  ) dut (
    .CLK(CLK), .RST(RST), .TICK(TICK), .START(START), .ABORT(ABORT),
    .TRAIN_MODE(TRAIN_MODE), .FRM_VALID(FRM_VALID), .FRM_READY(FRM_READY),
    .FRM_PIXELS(FRM_PIXELS), .FRM_LABEL(FRM_LABEL), .OUT_SPIKES(OUT_SPIKES),
    .IN_SPIKES(IN_SPIKES), .TEACH_SPIKES(TEACH_SPIKES), .EN_STDP(EN_STDP),
    .EN_ADDR(EN_ADDR), .BUSY(BUSY), .DONE(DONE), .UNDERRUN_CNT(UNDERRUN_CNT),
    .WINNER(WINNER), .WINNER_VALID(WINNER_VALID)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Pulse outputs after the TICK at step j of a frame; also pokes START mid-frame to show it is ignored.
  task automatic run_frame(input string tag, input bit train, input logic [N_IN-1:0] pix,
                           input logic [N_OUT-1:0] lab, input bit last, input bit drive_out);
    logic [N_OUT-1:0] exp_teach;
    bit               end_pulse;
    for (int j = 0; j < PERIOD; j++) begin
      OUT_SPIKES = (drive_out && j == 3) ? 6'b010010 : (drive_out && j == 4) ? 6'b000001 : 6'b0;
      START      = (j == 3);
      step();
      START      = 1'b0;
      OUT_SPIKES = '0;
      exp_teach  = '0;
      if (train && j == TRAIN_SLOT)               exp_teach = lab;
      if (train && j == PERIOD - 1 - UNTRAIN_OFS) exp_teach = ~lab;
      end_pulse  = (j == PERIOD - 1);
      chk({tag, " teach"}, 32'(TEACH_SPIKES), 32'(exp_teach));
      chk({tag, " en_addr"}, 32'(EN_ADDR), 32'(train && j == PERIOD - 2));
      chk({tag, " in_spikes"}, 32'(IN_SPIKES), end_pulse ? 32'(pix) : 32'h0);
      chk({tag, " done"}, 32'(DONE), 32'(end_pulse && last));
      chk({tag, " busy"}, 32'(BUSY), 32'h1);
      chk({tag, " en_stdp"}, 32'(EN_STDP), 32'(train && !(end_pulse && last)));
      chk({tag, " win_valid"}, 32'(WINNER_VALID), 32'(end_pulse && WTA && drive_out));
      chk({tag, " winner"}, 32'(WINNER), (end_pulse && WTA && drive_out) ? 32'h1 : 32'h0);
    end
  endtask

  // Two-frame session with TICK every cycle; TRAIN_MODE flips after START and must be ignored.
  task automatic session(input string tag, input bit train,
                         input logic [N_IN-1:0] pix1, input logic [N_OUT-1:0] lab1,
                         input logic [N_IN-1:0] pix2, input logic [N_OUT-1:0] lab2);
    TRAIN_MODE = train;
    START      = 1'b1;
    TICK       = 1'b1;
    step();
    START      = 1'b0;
    TRAIN_MODE = !train;
    chk({tag, " load busy"}, 32'(BUSY), 32'h1);
    chk({tag, " load ready"}, 32'(FRM_READY), 32'h1);
    chk({tag, " load en_stdp"}, 32'(EN_STDP), 32'(train));
    FRM_VALID  = 1'b1;
    FRM_PIXELS = pix1;
    FRM_LABEL  = lab1;
    step();
    chk({tag, " run ready"}, 32'(FRM_READY), 32'h0);
    FRM_PIXELS = '1;
    FRM_LABEL  = '0;
    run_frame({tag, " f1"}, train, pix1, lab1, 1'b0, 1'b1);
    chk({tag, " reload ready"}, 32'(FRM_READY), 32'h1);
    FRM_PIXELS = pix2;
    FRM_LABEL  = lab2;
    step();
    chk({tag, " in_spikes width"}, 32'(IN_SPIKES), 32'h0);
    chk({tag, " f2 ready"}, 32'(FRM_READY), 32'h0);
    FRM_PIXELS = '0;
    FRM_VALID  = 1'b0;
    run_frame({tag, " f2"}, train, pix2, lab2, 1'b1, 1'b0);
    step();
    chk({tag, " end done"}, 32'(DONE), 32'h0);
    chk({tag, " end busy"}, 32'(BUSY), 32'h0);
    chk({tag, " end in_spikes"}, 32'(IN_SPIKES), 32'h0);
    chk({tag, " underrun"}, 32'(UNDERRUN_CNT), 32'h0);
    TICK = 1'b0;
  endtask

  initial begin
    step();
    step();
    chk("reset busy", 32'(BUSY), 32'h0);
    chk("reset done", 32'(DONE), 32'h0);
    chk("reset ready", 32'(FRM_READY), 32'h0);
    chk("reset in_spikes", 32'(IN_SPIKES), 32'h0);
    chk("reset teach", 32'(TEACH_SPIKES), 32'h0);
    chk("reset en_stdp", 32'(EN_STDP), 32'h0);
    chk("reset en_addr", 32'(EN_ADDR), 32'h0);
    chk("reset underrun", 32'(UNDERRUN_CNT), 32'h0);
    chk("reset winner", 32'(WINNER), 32'h0);
    chk("reset win_valid", 32'(WINNER_VALID), 32'h0);
    RST = 1'b0;
    step();

    // Test 1: PERIOD=8, N_FRAMES=2, TRAIN_SLOT=1, UNTRAIN_OFS=2, train, label 6'b000100, TICK every cycle.
    session("t1", 1'b1, 8'hA5, 6'b000100, 8'h3C, 6'b100001);

    // Test 2: inference with the same stimulus; teachers and STDP stay quiet, bursts identical.
    session("t2", 1'b0, 8'hA5, 6'b000100, 8'h3C, 6'b100001);

    // Test 3: frame starvation in LOAD saturates a 2-bit counter, then reset mid-session.
    TRAIN_MODE = 1'b1;
    START      = 1'b1;
    step();
    START      = 1'b0;
    TICK       = 1'b1;
    step();
    step();
    chk("t3 underrun 2", 32'(UNDERRUN_CNT), 32'h2);
    chk("t3 no in_spikes", 32'(IN_SPIKES), 32'h0);
    chk("t3 no teach", 32'(TEACH_SPIKES), 32'h0);
    step();
    step();
    step();
    chk("t3 underrun sat", 32'(UNDERRUN_CNT), 32'h3);
    chk("t3 still load", 32'(FRM_READY), 32'h1);
    TICK = 1'b0;
    RST  = 1'b1;
    step();
    RST  = 1'b0;
    chk("t3 rst busy", 32'(BUSY), 32'h0);
    chk("t3 rst underrun", 32'(UNDERRUN_CNT), 32'h0);
    chk("t3 rst en_stdp", 32'(EN_STDP), 32'h0);

    // Test 4: ABORT together with START mid-RUN.
    TRAIN_MODE = 1'b1;
    START      = 1'b1;
    step();
    START      = 1'b0;
    TICK       = 1'b1;
    step();
    chk("t4 underrun 1", 32'(UNDERRUN_CNT), 32'h1);
    FRM_VALID  = 1'b1;
    FRM_PIXELS = 8'h81;
    FRM_LABEL  = 6'b000010;
    step();
    FRM_VALID  = 1'b0;
    chk("t4 hs no underrun", 32'(UNDERRUN_CNT), 32'h1);
    step();
    step();
    chk("t4 teach before abort", 32'(TEACH_SPIKES), 32'h02);
    ABORT = 1'b1;
    START = 1'b1;
    step();
    ABORT = 1'b0;
    START = 1'b0;
    chk("t4 abort busy", 32'(BUSY), 32'h0);
    chk("t4 abort done", 32'(DONE), 32'h0);
    chk("t4 abort teach", 32'(TEACH_SPIKES), 32'h0);
    chk("t4 abort en_stdp", 32'(EN_STDP), 32'h0);
    chk("t4 abort ready", 32'(FRM_READY), 32'h0);
    chk("t4 abort underrun kept", 32'(UNDERRUN_CNT), 32'h1);
    step();
    chk("t4 start ignored", 32'(BUSY), 32'h0);
    chk("t4 idle in_spikes", 32'(IN_SPIKES), 32'h0);
    TICK = 1'b0;

    // Test 5: TICK one cycle in three; counter advances only on TICK and pulses stay one cycle.
    TRAIN_MODE = 1'b1;
    START      = 1'b1;
    step();
    START      = 1'b0;
    chk("t5 start clears underrun", 32'(UNDERRUN_CNT), 32'h0);
    FRM_VALID  = 1'b1;
    FRM_PIXELS = 8'h5A;
    FRM_LABEL  = 6'b010000;
    step();
    FRM_VALID  = 1'b0;
    for (int j = 0; j < PERIOD; j++) begin
      TICK = 1'b1;
      step();
      TICK = 1'b0;
      chk("t5 teach", 32'(TEACH_SPIKES),
          (j == TRAIN_SLOT) ? 32'h10 : (j == PERIOD - 1 - UNTRAIN_OFS) ? 32'h2F : 32'h0);
      chk("t5 en_addr", 32'(EN_ADDR), 32'(j == PERIOD - 2));
      chk("t5 in_spikes", 32'(IN_SPIKES), (j == PERIOD - 1) ? 32'h5A : 32'h0);
      chk("t5 win_valid", 32'(WINNER_VALID), 32'h0);
      for (int g = 0; g < 2; g++) begin
        step();
        chk("t5 gap pulses", 32'({IN_SPIKES, TEACH_SPIKES, EN_ADDR}), 32'h0);
      end
    end
    chk("t5 waiting in load", 32'(FRM_READY), 32'h1);
    chk("t5 no tick no underrun", 32'(UNDERRUN_CNT), 32'h0);
    ABORT = 1'b1;
    step();
    ABORT = 1'b0;
    chk("t5 abort busy", 32'(BUSY), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
